// File: rtl/plot_bus_pkg.sv
// Shared definitions for the pixel-plot bus: screen geometry, colour codes,
// coordinate widths and the capture-map FSM encoding.
package plot_bus_pkg;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;

  localparam logic [2:0] COLOUR_ERASE = 3'b000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Increment an 8-bit count, sticking at the top value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/plot_capture_map_if.sv
// Plot bus and hit-query signals. The drawing side is the master; the
// capture map taps the bus as a slave and returns query results.
interface plot_capture_map_if;
  import plot_bus_pkg::*;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour;
  logic           plot;
  logic           clear_req;
  logic           query_valid;
  logic [X_W-1:0] query_x;
  logic [Y_W-1:0] query_y;
  logic           query_hit;
  logic           query_ack;

  modport master (
    output x, y, colour, plot, clear_req, query_valid, query_x, query_y,
    input  query_hit, query_ack
  );

  modport slave (
    input  x, y, colour, plot, clear_req, query_valid, query_x, query_y,
    output query_hit, query_ack
  );

endinterface

// File: rtl/plot_capture_map_sat_counter8.sv
// 8-bit event counter that saturates at 255; clear has priority over enable.
module sat_counter8
  import plot_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q;

  // Count register: synchronous reset, clear wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else if (clr_i) begin
      count_q <= 8'd0;
    end else if (en_i) begin
      count_q <= sat_inc8(count_q);
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/plot_capture_map.sv
// Occupancy bitmap of a fixed screen window, fed by the pixel-plot bus.
// Tracks lit-pixel count, bounding box of set events, and answers hit queries.
module plot_capture_map
  import plot_bus_pkg::*;
#(
  parameter int WIN_X0 = 8,
  parameter int WIN_Y0 = 8,
  parameter int WIN_W  = 32,
  parameter int WIN_H  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  plot_capture_map_if.slave bus,
  output logic              busy,
  output logic [10:0]       pix_count,
  output logic              bbox_valid,
  output logic [X_W-1:0]    bbox_xmin,
  output logic [X_W-1:0]    bbox_xmax,
  output logic [Y_W-1:0]    bbox_ymin,
  output logic [Y_W-1:0]    bbox_ymax,
  output logic [7:0]        oow_count,
  output logic [7:0]        drop_count
);

  localparam int XW = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int YW = (WIN_H > 1) ? $clog2(WIN_H) : 1;

  state_e           state_q, state_d;
  logic [YW-1:0]    row_q, row_d;
  logic [WIN_W-1:0] bitmap_q [WIN_H];
  logic [10:0]      pix_count_q;
  logic             bbox_valid_q;
  logic [X_W-1:0]   bbox_xmin_q, bbox_xmax_q;
  logic [Y_W-1:0]   bbox_ymin_q, bbox_ymax_q;
  logic             query_hit_q, query_ack_q;

  logic             plot_in_win_s, query_in_win_s;
  logic [XW-1:0]    px_off_s, qx_off_s;
  logic [YW-1:0]    py_off_s, qy_off_s;
  logic             cur_bit_s, query_bit_s;
  logic             set_ev_s, erase_ev_s, oow_ev_s, drop_ev_s, sweep_done_s;

  // Window membership, window-relative offsets and the events they imply.
  always_comb begin
    plot_in_win_s  = (32'(bus.x) >= WIN_X0) && (32'(bus.x) < WIN_X0 + WIN_W) &&
                     (32'(bus.y) >= WIN_Y0) && (32'(bus.y) < WIN_Y0 + WIN_H);
    query_in_win_s = (32'(bus.query_x) >= WIN_X0) && (32'(bus.query_x) < WIN_X0 + WIN_W) &&
                     (32'(bus.query_y) >= WIN_Y0) && (32'(bus.query_y) < WIN_Y0 + WIN_H);
    px_off_s    = XW'(32'(bus.x) - WIN_X0);
    py_off_s    = YW'(32'(bus.y) - WIN_Y0);
    qx_off_s    = XW'(32'(bus.query_x) - WIN_X0);
    qy_off_s    = YW'(32'(bus.query_y) - WIN_Y0);
    cur_bit_s   = bitmap_q[py_off_s][px_off_s];
    query_bit_s = bitmap_q[qy_off_s][qx_off_s] && query_in_win_s && (state_q == IDLE);
    set_ev_s    = bus.plot && plot_in_win_s && (state_q == IDLE) && (bus.colour != COLOUR_ERASE);
    erase_ev_s  = bus.plot && plot_in_win_s && (state_q == IDLE) && (bus.colour == COLOUR_ERASE);
    oow_ev_s    = bus.plot && !plot_in_win_s;
    drop_ev_s   = bus.plot && plot_in_win_s && (state_q == CLEAR);
  end

  // FSM state and sweep-row registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= {YW{1'b0}};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic: one row wiped per CLEAR cycle, clear_req ignored while sweeping.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    sweep_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          row_d   = {YW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (row_q == YW'(WIN_H - 1)) begin
          state_d      = IDLE;
          row_d        = {YW{1'b0}};
          sweep_done_s = 1'b1;
        end else begin
          row_d = row_q + YW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = {YW{1'b0}};
      end
    endcase
  end

  // Bitmap storage: row wipe while clearing, otherwise single-pixel set/erase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < WIN_H; r++) begin
        bitmap_q[r] <= {WIN_W{1'b0}};
      end
    end else if (state_q == CLEAR) begin
      bitmap_q[row_q] <= {WIN_W{1'b0}};
    end else if (set_ev_s) begin
      bitmap_q[py_off_s][px_off_s] <= 1'b1;
    end else if (erase_ev_s) begin
      bitmap_q[py_off_s][px_off_s] <= 1'b0;
    end else begin
      bitmap_q[0] <= bitmap_q[0];
    end
  end

  // Lit-pixel count: moves only when a bit actually changes value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_count_q <= 11'd0;
    end else if (sweep_done_s) begin
      pix_count_q <= 11'd0;
    end else if (set_ev_s && !cur_bit_s) begin
      pix_count_q <= pix_count_q + 11'd1;
    end else if (erase_ev_s && cur_bit_s) begin
      pix_count_q <= pix_count_q - 11'd1;
    end else begin
      pix_count_q <= pix_count_q;
    end
  end

  // Bounding box of set events; grows only, invalidated by a completed clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bbox_valid_q <= 1'b0;
      bbox_xmin_q  <= {X_W{1'b0}};
      bbox_xmax_q  <= {X_W{1'b0}};
      bbox_ymin_q  <= {Y_W{1'b0}};
      bbox_ymax_q  <= {Y_W{1'b0}};
    end else if (sweep_done_s) begin
      bbox_valid_q <= 1'b0;
    end else if (set_ev_s && !bbox_valid_q) begin
      bbox_valid_q <= 1'b1;
      bbox_xmin_q  <= bus.x;
      bbox_xmax_q  <= bus.x;
      bbox_ymin_q  <= bus.y;
      bbox_ymax_q  <= bus.y;
    end else if (set_ev_s) begin
      bbox_xmin_q  <= (bus.x < bbox_xmin_q) ? bus.x : bbox_xmin_q;
      bbox_xmax_q  <= (bus.x > bbox_xmax_q) ? bus.x : bbox_xmax_q;
      bbox_ymin_q  <= (bus.y < bbox_ymin_q) ? bus.y : bbox_ymin_q;
      bbox_ymax_q  <= (bus.y > bbox_ymax_q) ? bus.y : bbox_ymax_q;
    end else begin
      bbox_valid_q <= bbox_valid_q;
    end
  end

  // Query response: reads the pre-write bitmap, hit holds between queries.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      query_ack_q <= 1'b0;
      query_hit_q <= 1'b0;
    end else if (bus.query_valid) begin
      query_ack_q <= 1'b1;
      query_hit_q <= query_bit_s;
    end else begin
      query_ack_q <= 1'b0;
      query_hit_q <= query_hit_q;
    end
  end

  sat_counter8 u_oow_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (oow_ev_s),
    .clr_i   (1'b0),
    .count_o (oow_count)
  );

  sat_counter8 u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (drop_ev_s),
    .clr_i   (sweep_done_s),
    .count_o (drop_count)
  );

  assign busy          = (state_q == CLEAR);
  assign pix_count     = pix_count_q;
  assign bbox_valid    = bbox_valid_q;
  assign bbox_xmin     = bbox_xmin_q;
  assign bbox_xmax     = bbox_xmax_q;
  assign bbox_ymin     = bbox_ymin_q;
  assign bbox_ymax     = bbox_ymax_q;
  assign bus.query_hit = query_hit_q;
  assign bus.query_ack = query_ack_q;

endmodule
